// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the RV32I core: writeback source and load size encodings.
package pipeline_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    WB_ALU  = 2'b00,
    WB_LOAD = 2'b01,
    WB_PC4  = 2'b10,
    WB_RSVD = 2'b11
  } wb_sel_e;

  typedef enum logic [1:0] {
    LD_B    = 2'b00,
    LD_H    = 2'b01,
    LD_W    = 2'b10,
    LD_RSVD = 2'b11
  } ld_size_e;

endpackage

// File: rtl/load_align.sv
// Combinational load aligner: extracts byte/half/word at a byte offset, extends it,
// and flags misaligned accesses. Shared with the cache refill path.
module load_align
  import pipeline_pkg::*;
#(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] i_ld_data,
  input  logic [1:0]   i_off,
  input  ld_size_e     i_size,
  input  logic         i_unsigned,
  output logic [W-1:0] o_data,
  output logic         o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_ld_data[{i_off, 3'b000} +: 8];
  assign w_half = i_ld_data[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_data     = i_ld_data;
    o_misalign = 1'b0;
    unique case (i_size)
      LD_B: begin
        o_data = i_unsigned ? {{(W-8){1'b0}}, w_byte} : {{(W-8){w_byte[7]}}, w_byte};
      end
      LD_H: begin
        o_data     = i_unsigned ? {{(W-16){1'b0}}, w_half} : {{(W-16){w_half[15]}}, w_half};
        o_misalign = i_off[0];
      end
      // reserved size behaves as a word access
      LD_W, LD_RSVD: begin
        o_data     = i_ld_data;
        o_misalign = |i_off;
      end
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and register-file writeback with stall/flush and retire-once.
// Optional macro WB_INSTRET_EN adds a 64-bit retired-instruction counter (instret_o).
module mem_wb_stage #(
  parameter int unsigned     XLEN           = pipeline_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC_PLUS4 = 32'h0000_0004
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            stall_i,
  input  logic            flush_i,
  input  logic            valid_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] alu_data_i,
  input  logic [XLEN-1:0] ld_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_wren_i,
  input  logic [1:0]      wb_sel_i,
  input  logic [1:0]      ld_size_i,
  input  logic            ld_unsigned_i,
  output logic            rd_wren_o,
  output logic [4:0]      rd_addr_o,
  output logic [XLEN-1:0] rd_data_o,
  output logic            wb_valid_o,
  output logic            misalign_o
`ifdef WB_INSTRET_EN
  ,
  output logic [63:0]     instret_o
`endif
);

  import pipeline_pkg::*;

  logic            r_valid_q;
  logic            r_fired_q;
  logic            r_wren_q;
  logic [4:0]      r_rd_addr_q;
  logic [XLEN-1:0] r_data_q;
  logic            r_misalign_q;
  logic [XLEN-1:0] r_pc_plus4_q;
  logic            r_pc4_sel_q;

  wb_sel_e         w_sel;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_ld_data;
  logic            w_ld_misalign;
  logic [XLEN-1:0] w_wb_data;
  logic            w_misalign;
  logic            w_wren;

  assign w_sel      = wb_sel_e'(wb_sel_i);
  assign w_pc_plus4 = pc_i + XLEN'(4);

  load_align #(
    .W (XLEN)
  ) u_load_align (
    .i_ld_data  (ld_data_i),
    .i_off      (alu_data_i[1:0]),
    .i_size     (ld_size_e'(ld_size_i)),
    .i_unsigned (ld_unsigned_i),
    .o_data     (w_ld_data),
    .o_misalign (w_ld_misalign)
  );

  always_comb begin
    w_wb_data  = '0;
    w_misalign = 1'b0;
    unique case (w_sel)
      WB_ALU:  w_wb_data = alu_data_i;
      WB_LOAD: begin
        w_wb_data  = w_ld_data;
        w_misalign = w_ld_misalign;
      end
      WB_PC4:  w_wb_data = w_pc_plus4;
      WB_RSVD: w_wb_data = '0;
    endcase
  end

  // fired_q remembers that a stalled instruction already wrote, so it never writes twice
  assign w_wren = r_valid_q & r_wren_q & (|r_rd_addr_q) & ~r_misalign_q & ~r_fired_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_valid_q    <= 1'b0;
      r_fired_q    <= 1'b0;
      r_wren_q     <= 1'b0;
      r_rd_addr_q  <= '0;
      r_data_q     <= '0;
      r_misalign_q <= 1'b0;
      r_pc_plus4_q <= RESET_PC_PLUS4;
      r_pc4_sel_q  <= 1'b0;
    end else if (flush_i) begin
      r_valid_q <= 1'b0;
      r_fired_q <= 1'b0;
    end else if (stall_i) begin
      r_fired_q <= r_fired_q | w_wren;
    end else begin
      r_valid_q    <= valid_i;
      r_fired_q    <= 1'b0;
      r_wren_q     <= rd_wren_i;
      r_rd_addr_q  <= rd_addr_i;
      r_data_q     <= w_wb_data;
      r_misalign_q <= w_misalign;
      r_pc_plus4_q <= w_pc_plus4;
      r_pc4_sel_q  <= (w_sel == WB_PC4);
    end
  end

  assign rd_wren_o  = w_wren;
  assign rd_addr_o  = r_rd_addr_q;
  assign rd_data_o  = r_data_q;
  assign wb_valid_o = r_valid_q;
  assign misalign_o = r_valid_q & r_misalign_q;

  // debug copy of PC+4 must agree with the writeback data of a PC+4 instruction
  a_pc4_consistent : assert property (@(posedge clk_i) disable iff (rst_i)
    (r_valid_q && r_pc4_sel_q) |-> (r_data_q == r_pc_plus4_q));

`ifdef WB_INSTRET_EN
  logic        w_advance;
  logic [63:0] r_instret_q;

  // an instruction counts when it leaves WB or on its first write while stalled
  assign w_advance = ~stall_i | flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_instret_q <= '0;
    end else if (r_valid_q & ~r_fired_q & ~r_misalign_q & (w_advance | w_wren)) begin
      r_instret_q <= r_instret_q + 64'd1;
    end
  end

  assign instret_o = r_instret_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed scoreboard bench for mem_wb_stage: expectations queued at drive, checked after each edge.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, flush, valid;
  logic [31:0] pc, alu, ld;
  logic [4:0]  rd;
  logic        wr;
  logic [1:0]  sel, sz;
  logic        uns;
  logic        o_wren;
  logic [4:0]  o_addr;
  logic [31:0] o_data;
  logic        o_valid, o_mis;
`ifdef WB_INSTRET_EN
  logic [63:0] o_instret;
`endif

  typedef struct packed {
    logic [15:0] id;
    logic        wren;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        valid;
    logic        mis;
    logic        chkd;
  } exp_t;

  exp_t q[$];
  exp_t last;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   sid   = 0;

  localparam logic [31:0] LDW = 32'h8765_43F1;

  always #5 clk = ~clk;

  mem_wb_stage #(
    .XLEN           (32),
    .RESET_PC_PLUS4 (32'h0000_0004)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .stall_i       (stall),
    .flush_i       (flush),
    .valid_i       (valid),
    .pc_i          (pc),
    .alu_data_i    (alu),
    .ld_data_i     (ld),
    .rd_addr_i     (rd),
    .rd_wren_i     (wr),
    .wb_sel_i      (sel),
    .ld_size_i     (sz),
    .ld_unsigned_i (uns),
    .rd_wren_o     (o_wren),
    .rd_addr_o     (o_addr),
    .rd_data_o     (o_data),
    .wb_valid_o    (o_valid),
    .misalign_o    (o_mis)
`ifdef WB_INSTRET_EN
    ,
    .instret_o     (o_instret)
`endif
  );

  task automatic chk1(input int id, input string f, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL s%0d.%s observed %h expected %h", id, f, obs, exp);
    end
  endtask

  task automatic check_out();
    exp_t e;
    if (q.size() == 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_empty observed 0 expected 1");
    end else begin
      e = q.pop_front();
      chk1(int'(e.id), "rd_wren", 64'(o_wren), 64'(e.wren));
      chk1(int'(e.id), "rd_addr", 64'(o_addr), 64'(e.addr));
      if (e.chkd) chk1(int'(e.id), "rd_data", 64'(o_data), 64'(e.data));
      chk1(int'(e.id), "wb_valid", 64'(o_valid), 64'(e.valid));
      chk1(int'(e.id), "misalign", 64'(o_mis), 64'(e.mis));
    end
  endtask

  task automatic push(input logic ewren, input logic [4:0] eaddr, input logic [31:0] edata,
                      input logic evalid, input logic emis, input logic chkd);
    exp_t e;
    e.id = 16'(sid);
    e.wren = ewren;
    e.addr = eaddr;
    e.data = edata;
    e.valid = evalid;
    e.mis = emis;
    e.chkd = chkd;
    sid++;
    last = e;
    q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [1:0] z, input logic u,
                       input logic [31:0] a, input logic [31:0] l, input logic [31:0] p,
                       input logic [4:0] r, input logic w);
    valid = v; sel = s; sz = z; uns = u; alu = a; ld = l; pc = p; rd = r; wr = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_out();
  endtask

  // capture one MEM-stage instruction and expect it on the WB port next cycle
  task automatic stepc(input logic v, input logic [1:0] s, input logic [1:0] z, input logic u,
                       input logic [31:0] a, input logic [31:0] l, input logic [31:0] p,
                       input logic [4:0] r, input logic w,
                       input logic ewren, input logic [31:0] edata, input logic emis,
                       input logic chkd);
    stall = 1'b0;
    flush = 1'b0;
    drive(v, s, z, u, a, l, p, r, w);
    push(ewren, r, edata, v, emis, chkd);
    tick();
  endtask

  // stall with unrelated MEM inputs; WB contents must hold
  task automatic hold(input logic ewren);
    stall = 1'b1;
    flush = 1'b0;
    drive(1'b1, 2'b00, 2'b10, 1'b0, 32'hDEAD_BEEF, 32'h0, 32'h0, 5'd31, 1'b1);
    push(ewren, last.addr, last.data, last.valid, last.mis, 1'b1);
    tick();
  endtask

  // asynchronous reset mid-cycle while a valid capture is pending under stall
  task automatic async_reset();
    stall = 1'b1;
    flush = 1'b0;
    drive(1'b1, 2'b00, 2'b10, 1'b0, 32'h0000_ABCD, 32'h0, 32'h0, 5'd12, 1'b1);
    #3;
    rst = 1'b1;
    #1;
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_out();
    @(posedge clk);
    #1;
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_out();
    rst = 1'b0;
    stall = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b0, 2'b00, 2'b00, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0, 1'b0);
    #2;
    push(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 1'b1);
    check_out();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // bubble after reset: nothing written
    stepc(0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 1);

    // loads from 0x8765_43F1 into x5
    stepc(1, 2'b01, 2'b00, 0, 32'h0000_1000, LDW, 32'h0, 5'd5, 1, 1, 32'hFFFF_FFF1, 0, 1);
    stepc(1, 2'b01, 2'b00, 1, 32'h0000_1000, LDW, 32'h0, 5'd5, 1, 1, 32'h0000_00F1, 0, 1);
    stepc(1, 2'b01, 2'b01, 0, 32'h0000_1002, LDW, 32'h0, 5'd5, 1, 1, 32'hFFFF_8765, 0, 1);
    stepc(1, 2'b01, 2'b01, 1, 32'h0000_1002, LDW, 32'h0, 5'd5, 1, 1, 32'h0000_8765, 0, 1);
    stepc(1, 2'b01, 2'b10, 0, 32'h0000_1000, LDW, 32'h0, 5'd5, 1, 1, 32'h8765_43F1, 0, 1);
    stepc(1, 2'b01, 2'b00, 0, 32'h0000_1003, LDW, 32'h0, 5'd5, 1, 1, 32'hFFFF_FF87, 0, 1);
    stepc(1, 2'b01, 2'b11, 0, 32'h0000_1000, LDW, 32'h0, 5'd5, 1, 1, 32'h8765_43F1, 0, 1);

    // misaligned loads suppress the write; ALU op with odd low bits does not
    stepc(1, 2'b01, 2'b10, 0, 32'h0000_1001, LDW, 32'h0, 5'd5, 1, 0, 32'h0, 1, 0);
    stepc(1, 2'b01, 2'b01, 0, 32'h0000_1003, LDW, 32'h0, 5'd5, 1, 0, 32'h0, 1, 0);
    stepc(1, 2'b01, 2'b11, 0, 32'h0000_1002, LDW, 32'h0, 5'd5, 1, 0, 32'h0, 1, 0);
    stepc(1, 2'b00, 2'b10, 0, 32'h0000_2001, LDW, 32'h0, 5'd6, 1, 1, 32'h0000_2001, 0, 1);

    // PC+4, wraparound, x0, no-write, reserved source
    stepc(1, 2'b10, 2'b00, 0, 32'h0, 32'h0, 32'h0000_0100, 5'd1, 1, 1, 32'h0000_0104, 0, 1);
    stepc(1, 2'b10, 2'b00, 0, 32'h0, 32'h0, 32'hFFFF_FFFC, 5'd1, 1, 1, 32'h0000_0000, 0, 1);
    stepc(1, 2'b00, 2'b00, 0, 32'h0000_0055, 32'h0, 32'h0, 5'd0, 1, 0, 32'h0000_0055, 0, 1);
    stepc(1, 2'b00, 2'b00, 0, 32'h0000_0066, 32'h0, 32'h0, 5'd4, 0, 0, 32'h0000_0066, 0, 1);
    stepc(1, 2'b11, 2'b00, 0, 32'h0000_0077, 32'h0, 32'h0, 5'd3, 1, 1, 32'h0000_0000, 0, 1);

    // stalled write to x7 fires exactly once, contents held
    stepc(1, 2'b00, 2'b00, 0, 32'h0000_1234, 32'h0, 32'h0, 5'd7, 1, 1, 32'h0000_1234, 0, 1);
    hold(0);
    hold(0);
    hold(0);
    stepc(0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 1);

    // flush together with stall inserts a bubble
    stepc(1, 2'b00, 2'b00, 0, 32'h0000_0077, 32'h0, 32'h0, 5'd8, 1, 1, 32'h0000_0077, 0, 1);
    stall = 1'b1;
    flush = 1'b1;
    drive(1'b1, 2'b00, 2'b00, 1'b0, 32'h0000_0999, 32'h0, 32'h0, 5'd10, 1'b1);
    push(1'b0, 5'd8, 32'h0000_0077, 1'b0, 1'b0, 1'b1);
    tick();
    stepc(1, 2'b00, 2'b00, 0, 32'h0000_0123, 32'h0, 32'h0, 5'd11, 1, 1, 32'h0000_0123, 0, 1);

    // reset in the middle of a stalled write
    stepc(1, 2'b00, 2'b00, 0, 32'h0000_0099, 32'h0, 32'h0, 5'd9, 1, 1, 32'h0000_0099, 0, 1);
    async_reset();
    stepc(0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 1);
    stepc(1, 2'b00, 2'b00, 0, 32'h0000_00AA, 32'h0, 32'h0, 5'd9, 1, 1, 32'h0000_00AA, 0, 1);

`ifdef WB_INSTRET_EN
    async_reset();
    chk1(sid, "instret_rst", o_instret, 64'd0);
    stepc(1, 2'b00, 2'b00, 0, 32'h0000_0011, 32'h0, 32'h0, 5'd1, 1, 1, 32'h0000_0011, 0, 1);
    stepc(1, 2'b00, 2'b00, 0, 32'h0000_0022, 32'h0, 32'h0, 5'd2, 1, 1, 32'h0000_0022, 0, 1);
    stepc(0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 1);
    stepc(1, 2'b01, 2'b10, 0, 32'h0000_1000, 32'hCAFE_BABE, 32'h0, 5'd3, 1, 1, 32'hCAFE_BABE, 0, 1);
    stepc(0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 1);
    stepc(1, 2'b01, 2'b10, 0, 32'h0000_1001, LDW, 32'h0, 5'd4, 1, 0, 32'h0, 1, 0);
    stepc(1, 2'b00, 2'b00, 0, 32'h0000_2000, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0000_2000, 0, 1);
    stepc(1, 2'b00, 2'b00, 0, 32'h0000_0066, 32'h0, 32'h0, 5'd6, 1, 1, 32'h0000_0066, 0, 1);
    hold(0);
    hold(0);
    hold(0);
    stepc(1, 2'b10, 2'b00, 0, 32'h0, 32'h0, 32'h0000_0200, 5'd7, 1, 1, 32'h0000_0204, 0, 1);
    stepc(1, 2'b00, 2'b00, 0, 32'h0000_0088, 32'h0, 32'h0, 5'd0, 1, 0, 32'h0000_0088, 0, 1);
    stepc(1, 2'b01, 2'b00, 0, 32'h0000_1003, LDW, 32'h0, 5'd9, 1, 1, 32'hFFFF_FF87, 0, 1);
    stepc(0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 1);
    stepc(0, 2'b00, 2'b00, 0, 32'h0, 32'h0, 32'h0, 5'd0, 0, 0, 32'h0, 0, 1);
    chk1(sid, "instret", o_instret, 64'd8);
`endif

    if (q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $error("FAIL sb_leftover observed %0d expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
